multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control unit sitting directly upstream of the datapath.
- Consumes the registered instruction `Instr` and the live `ALUFlags`.
- Sequences fetch/decode/execute/writeback with a Moore FSM.
- Drives every datapath control input, including `opMul` and `IsLongMul` for MUL/UMULL/SMULL. Holds the architectural NZCV flags and evaluates condition codes.

Parameters:
STATE_W, 4, width of state encoding and of the `state` debug output.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH and clears flags
Instr  in  32  instruction register contents from datapath
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  PC register enable
RegWrite  out  1  regfile write enable (wa3)
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0: PC, 1: Result as memory address
RegSrc  out  2  [0]=1 selects R15 on RA1; [1]=1 selects Rd on RA2
ALUSrcA  out  1  0: A, 1: PC
ALUSrcB  out  2  00: WriteData, 01: ExtImm, 10: constant 4
ResultSrc  out  2  00: ALUOut, 01: Data, 10: ALUResult
ImmSrc  out  2  00: imm8 DP, 01: imm12 mem, 10: imm24 branch
ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 MUL, 0110 UMULL, 0111 SMULL
opMul  out  1  multiply-class instruction in IR (register remap)
IsLongMul  out  1  long-multiply high-word write / ALUOut long mode
Flags  out  4  architectural NZCV register
state  out  STATE_W  current FSM state (visualisation)

Behaviour:
- Reset is asynchronous and active-high on `reset`.
  - While reset is asserted, or after it: `state` = FETCH (0) and `Flags` = 0000. Nothing else is stored.
  - Outputs are Moore-decoded from the state, so reset values equal the FETCH decode.
  - Reset mid-instruction abandons the instruction; no partial writes occur after deassertion.
- Decode:
  - `op` = `Instr[27:26]`.
  - MUL class = (`Instr[27:24]`==0000 && `Instr[7:4]`==1001). Long = `Instr[23]`; signed = `Instr[22]`.
  - S = `Instr[20]`; L = `Instr[20]` for memory ops; I = `Instr[25]`.
- DP cmd (`Instr[24:21]`) mapping:

  | cmd | ALUControl | note |
  |---|---|---|
  | 0100 | ADD | |
  | 0010 | SUB | |
  | 0000 | AND | |
  | 1100 | ORR | |
  | 0001 | EOR | |
  | 1010 | CMP | SUB, NoWrite |

  Any other cmd is illegal.
- `opMul` = MUL class, combinational from `Instr`, every state.
- Condition (`Instr[31:28]`): the 14 standard ARM codes evaluated on `Flags`; 1110 = always, 1111 = never.
  - The result is latched into `CondExReg` at the end of DECODE and gates all later writes of that instruction.
- States and transitions:
  - FETCH(0): AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 -> DECODE.
  - DECODE(1): ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Next state:
    - MEMADR if op=01.
    - BRANCH if op=10.
    - MULEX if MUL class.
    - EXECI if DP with I=1.
    - EXECR if DP with I=0.
    - else illegal.
  - MEMADR(2): ALUSrcA=0, ALUSrcB=01, ADD, ImmSrc=01 -> MEMRD if L, else MEMWR.
  - MEMRD(3): AdrSrc=1, ResultSrc=00 -> MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=CondExReg -> FETCH.
  - MEMWR(5): AdrSrc=1, ResultSrc=00, RegSrc[1]=1, MemWrite=CondExReg -> FETCH.
  - EXECR(6) / EXECI(7): ALUSrcA=0, ALUSrcB=00 / 01 respectively, ImmSrc=00, DP ALUControl -> ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=CondExReg && !CMP -> FETCH.
  - BRANCH(9): RegSrc[0]=1, ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=CondExReg -> FETCH.
  - MULEX(10): ALUSrcA=0, ALUSrcB=00, ALUControl = MUL, UMULL (long && !signed), or SMULL (long && signed) -> MULWB.
  - MULWB(11): ResultSrc=00, RegWrite=CondExReg, IsLongMul=long && CondExReg -> FETCH.
  - `IsLongMul` is also 1 in MULEX for long ops, so ALUOut captures both halves.
- RegSrc[1]=1 in DECODE/MEMADR/MEMWR for store ops.
- PC writeback: in MEMWB/ALUWB, if `Instr[15:12]`==1111 and the write is enabled, PCWrite=1 as well.
- Unlisted outputs are 0 in every state.
- Flags update, only when S && CondExReg, at the clock edge ending the state:
  - EXECR/EXECI: NZ from ALUFlags; CV only for ADD/SUB/CMP, held otherwise.
  - MULEX: NZ only.
  - CMP updates flags regardless of S.
- Latency (cycles): DP 4, LDR 5, STR 4, B 3, MUL/UMULL/SMULL 4.

Optional Feature:
- Macro: `ILLEGAL_HALT_EN`.
- Defined: illegal decode -> HALT(12). HALT drives all enables 0, PCWrite 0, IRWrite 0, and stays there until reset.
- Undefined: illegal decode -> FETCH, i.e. the instruction executes as a 2-cycle NOP. The PC is already advanced, so execution continues.

Test Plan:
- Reset pulse mid-EXECR (ADD R1,R2,R3) -> state=0, Flags=0000 asynchronously; after release the next cycle shows FETCH with IRWrite=1, PCWrite=1.
- ADDS R0,R1,#1 with R1=0xFFFFFFFF (0xE2910001) -> states 0,1,7,8; Flags=0110 after EXECI; RegWrite=1 only in ALUWB.
- CMP R0,R0 then BNE (0x1A000002) -> Flags Z=1, CondExReg=0, PCWrite=0 in BRANCH; next, BEQ -> PCWrite=1 in BRANCH.
- LDR R2,[R0,#4] (0xE5902004) -> states 0,1,2,3,4; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. STR (0xE5802004) -> MemWrite=1 only in MEMWR.
- SMULL R4,R5,R2,R3 (0xE0C54392) -> opMul=1 throughout; ALUControl=0111 in MULEX; IsLongMul=1 in MULEX and MULWB; RegWrite=1 in MULWB. UMULL (0xE0854392) -> ALUControl=0110.
- Instr=0xE1A00000-class illegal cmd (1101) -> with `ILLEGAL_HALT_EN` state=12 held 10 cycles with all enables 0; without it -> state sequence 0,1,0 with no writes.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle control unit and its datapath.
// The master modport is the control unit: it consumes the instruction
// register and live ALU flags and drives every datapath control input.
interface multicycle_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [31:0]        Instr;
  logic [3:0]         ALUFlags;
  logic               PCWrite;
  logic               RegWrite;
  logic               MemWrite;
  logic               IRWrite;
  logic               AdrSrc;
  logic [1:0]         RegSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic [1:0]         ImmSrc;
  logic [3:0]         ALUControl;
  logic               opMul;
  logic               IsLongMul;
  logic [3:0]         Flags;
  logic [STATE_W-1:0] state;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, ALUControl, opMul, IsLongMul, Flags,
           state
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, ALUControl, opMul, IsLongMul, Flags,
           state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/
// writeback, ARM condition evaluation and the architectural NZCV register.
// Optional build macro ILLEGAL_HALT_EN: illegal decodes park the FSM in
// HALT until reset; without it they fall back to FETCH as a 2-cycle NOP.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 'd0,  DECODE = 'd1,  MEMADR = 'd2,  MEMRD  = 'd3,
    MEMWB  = 'd4,  MEMWR  = 'd5,  EXECR  = 'd6,  EXECI  = 'd7,
    ALUWB  = 'd8,  BRANCH = 'd9,  MULEX  = 'd10, MULWB  = 'd11,
    HALT   = 'd12
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_UMULL = 4'b0110;
  localparam logic [3:0] ALU_SMULL = 4'b0111;

  state_t     state_q;
  logic [3:0] flags_q;
  logic       condex_q;

  // Instruction field decode
  logic [1:0] op;
  logic [3:0] cmd;
  logic       is_mul, is_long, is_signed, sbit, ibit, is_store, rd_pc;
  logic       dp_legal, is_cmp, cv_arith;
  logic [3:0] dp_alu;
  logic       unused_instr_bits;

  assign op        = bus.Instr[27:26];
  assign cmd       = bus.Instr[24:21];
  assign is_mul    = (bus.Instr[27:24] == 4'b0000) && (bus.Instr[7:4] == 4'b1001);
  assign is_long   = bus.Instr[23];
  assign is_signed = bus.Instr[22];
  assign sbit      = bus.Instr[20];
  assign ibit      = bus.Instr[25];
  assign is_store  = (op == 2'b01) && !sbit;
  assign rd_pc     = (bus.Instr[15:12] == 4'hF);
  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:8], bus.Instr[3:0]};

  // DP command to ALU operation; CMP is a SUB whose result is discarded
  always_comb begin
    dp_legal = 1'b1;
    is_cmp   = 1'b0;
    cv_arith = 1'b0;
    dp_alu   = ALU_ADD;
    case (cmd)
      4'b0100: begin dp_alu = ALU_ADD; cv_arith = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; cv_arith = 1'b1; end
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b0001: dp_alu = ALU_EOR;
      4'b1010: begin dp_alu = ALU_SUB; cv_arith = 1'b1; is_cmp = 1'b1; end
      default: dp_legal = 1'b0;
    endcase
  end

  // ARM condition-code evaluation against the NZCV register
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // State sequencing, condition latch and flag register updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          condex_q <= cond_pass(bus.Instr[31:28], flags_q);
          if (op == 2'b01)                 state_q <= MEMADR;
          else if (op == 2'b10)            state_q <= BRANCH;
          else if (is_mul)                 state_q <= MULEX;
          else if (op == 2'b00 && dp_legal) state_q <= ibit ? EXECI : EXECR;
          else
`ifdef ILLEGAL_HALT_EN
                                           state_q <= HALT;
`else
                                           state_q <= FETCH;
`endif
        end
        MEMADR: state_q <= sbit ? MEMRD : MEMWR;
        MEMRD:  state_q <= MEMWB;
        EXECR, EXECI: begin
          state_q <= ALUWB;
          if (condex_q && (sbit || is_cmp))
            flags_q <= {bus.ALUFlags[3:2], cv_arith ? bus.ALUFlags[1:0] : flags_q[1:0]};
        end
        MULEX: begin
          state_q <= MULWB;
          if (condex_q && sbit)
            flags_q[3:2] <= bus.ALUFlags[3:2];
        end
        HALT:   state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Moore decode of datapath controls from the current state
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.RegSrc     = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.IsLongMul  = 1'b0;
    case (state_q)
      FETCH: begin
        bus.IRWrite = 1'b1;  bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10;
        bus.ResultSrc = 2'b10; bus.PCWrite = 1'b1;
      end
      DECODE: begin
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
        bus.RegSrc[1] = is_store;
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01; bus.ImmSrc = 2'b01; bus.RegSrc[1] = is_store;
      end
      MEMRD: bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01; bus.RegWrite = condex_q;
        bus.PCWrite   = condex_q && rd_pc;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1; bus.RegSrc[1] = 1'b1; bus.MemWrite = condex_q;
      end
      EXECR: bus.ALUControl = dp_alu;
      EXECI: begin bus.ALUSrcB = 2'b01; bus.ALUControl = dp_alu; end
      ALUWB: begin
        bus.RegWrite = condex_q && !is_cmp;
        bus.PCWrite  = condex_q && !is_cmp && rd_pc;
      end
      BRANCH: begin
        bus.RegSrc[0] = 1'b1; bus.ALUSrcB = 2'b01; bus.ImmSrc = 2'b10;
        bus.ResultSrc = 2'b10; bus.PCWrite = condex_q;
      end
      MULEX: begin
        bus.ALUControl = !is_long ? ALU_MUL : (is_signed ? ALU_SMULL : ALU_UMULL);
        bus.IsLongMul  = is_long;
      end
      MULWB: begin
        bus.RegWrite = condex_q; bus.IsLongMul = is_long && condex_q;
      end
      default: ;
    endcase
  end

  assign bus.opMul = is_mul;
  assign bus.Flags = flags_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table covering each
// instruction class, plus hand sequences for async reset and illegal decode.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   nchecks;
  int   nerrs;

  multicycle_ctrl_if #(.STATE_W(4)) bus ();

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  aluf;
    logic [3:0]  st;
    logic [19:0] ctrl;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[$];

  // {PCWrite,RegWrite,MemWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,
  //  ResultSrc,ImmSrc,ALUControl,opMul,IsLongMul}
  function automatic logic [19:0] cv(input logic pcw, rw, mw, irw, adr,
                                     input logic [1:0] rs, input logic sa,
                                     input logic [1:0] sb, rsrc, imm,
                                     input logic [3:0] alu, input logic om, il);
    return {pcw, rw, mw, irw, adr, rs, sa, sb, rsrc, imm, alu, om, il};
  endfunction

  function automatic logic [19:0] actual_ctrl();
    return {bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.AdrSrc,
            bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
            bus.ALUControl, bus.opMul, bus.IsLongMul};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] i, input logic [3:0] af, input logic [3:0] st,
                     input logic [19:0] c, input logic [3:0] f);
    vec_t v;
    v.instr = i; v.aluf = af; v.st = st; v.ctrl = c; v.flags = f;
    vecs.push_back(v);
  endtask

  logic [19:0] fe0, fe1, de0, de1, de_st, halt_ctrl;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nchecks = 0;
    nerrs   = 0;
    fe0   = cv(1,0,0,1,0,2'b00,1,2'b10,2'b10,2'b00,4'h0,0,0);
    fe1   = cv(1,0,0,1,0,2'b00,1,2'b10,2'b10,2'b00,4'h0,1,0);
    de0   = cv(0,0,0,0,0,2'b00,1,2'b10,2'b10,2'b00,4'h0,0,0);
    de1   = cv(0,0,0,0,0,2'b00,1,2'b10,2'b10,2'b00,4'h0,1,0);
    de_st = cv(0,0,0,0,0,2'b10,1,2'b10,2'b10,2'b00,4'h0,0,0);
    halt_ctrl = 20'h0;

    // ADDS R0,R1,#1 -> Z,C
    add(32'hE2910001, 4'b0000, 4'd0, fe0, 4'b0000);
    add(32'hE2910001, 4'b0000, 4'd1, de0, 4'b0000);
    add(32'hE2910001, 4'b0110, 4'd7, cv(0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,4'b0000,0,0), 4'b0000);
    add(32'hE2910001, 4'b0000, 4'd8, cv(0,1,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,0,0), 4'b0110);
    // ANDS R0,R0,#0: NZ from ALU, CV held
    add(32'hE2100000, 4'b0000, 4'd0, fe0, 4'b0110);
    add(32'hE2100000, 4'b0000, 4'd1, de0, 4'b0110);
    add(32'hE2100000, 4'b1011, 4'd7, cv(0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,4'b0010,0,0), 4'b0110);
    add(32'hE2100000, 4'b0000, 4'd8, cv(0,1,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,0,0), 4'b1010);
    // CMP R0,R0: flags written, no register write
    add(32'hE1500000, 4'b0000, 4'd0, fe0, 4'b1010);
    add(32'hE1500000, 4'b0000, 4'd1, de0, 4'b1010);
    add(32'hE1500000, 4'b0110, 4'd6, cv(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0001,0,0), 4'b1010);
    add(32'hE1500000, 4'b0000, 4'd8, 20'h0, 4'b0110);
    // BNE not taken
    add(32'h1A000002, 4'b0000, 4'd0, fe0, 4'b0110);
    add(32'h1A000002, 4'b0000, 4'd1, de0, 4'b0110);
    add(32'h1A000002, 4'b0000, 4'd9, cv(0,0,0,0,0,2'b01,0,2'b01,2'b10,2'b10,4'b0000,0,0), 4'b0110);
    // BEQ taken
    add(32'h0A000002, 4'b0000, 4'd0, fe0, 4'b0110);
    add(32'h0A000002, 4'b0000, 4'd1, de0, 4'b0110);
    add(32'h0A000002, 4'b0000, 4'd9, cv(1,0,0,0,0,2'b01,0,2'b01,2'b10,2'b10,4'b0000,0,0), 4'b0110);
    // LDR R2,[R0,#4]
    add(32'hE5902004, 4'b0000, 4'd0, fe0, 4'b0110);
    add(32'hE5902004, 4'b0000, 4'd1, de0, 4'b0110);
    add(32'hE5902004, 4'b0000, 4'd2, cv(0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b01,4'b0000,0,0), 4'b0110);
    add(32'hE5902004, 4'b0000, 4'd3, cv(0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,4'b0000,0,0), 4'b0110);
    add(32'hE5902004, 4'b0000, 4'd4, cv(0,1,0,0,0,2'b00,0,2'b00,2'b01,2'b00,4'b0000,0,0), 4'b0110);
    // STR R2,[R0,#4]
    add(32'hE5802004, 4'b0000, 4'd0, fe0, 4'b0110);
    add(32'hE5802004, 4'b0000, 4'd1, de_st, 4'b0110);
    add(32'hE5802004, 4'b0000, 4'd2, cv(0,0,0,0,0,2'b10,0,2'b01,2'b00,2'b01,4'b0000,0,0), 4'b0110);
    add(32'hE5802004, 4'b0000, 4'd5, cv(0,0,1,0,1,2'b10,0,2'b00,2'b00,2'b00,4'b0000,0,0), 4'b0110);
    // SMULL R4,R5,R2,R3
    add(32'hE0C54392, 4'b0000, 4'd0, fe1, 4'b0110);
    add(32'hE0C54392, 4'b0000, 4'd1, de1, 4'b0110);
    add(32'hE0C54392, 4'b1111, 4'd10, cv(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0111,1,1), 4'b0110);
    add(32'hE0C54392, 4'b0000, 4'd11, cv(0,1,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,1,1), 4'b0110);
    // UMULL R4,R5,R2,R3
    add(32'hE0854392, 4'b0000, 4'd0, fe1, 4'b0110);
    add(32'hE0854392, 4'b0000, 4'd1, de1, 4'b0110);
    add(32'hE0854392, 4'b0000, 4'd10, cv(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0110,1,1), 4'b0110);
    add(32'hE0854392, 4'b0000, 4'd11, cv(0,1,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,1,1), 4'b0110);
    // MULS R0,R2,R3: NZ only
    add(32'hE0100392, 4'b0000, 4'd0, fe1, 4'b0110);
    add(32'hE0100392, 4'b0000, 4'd1, de1, 4'b0110);
    add(32'hE0100392, 4'b1001, 4'd10, cv(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0101,1,0), 4'b0110);
    add(32'hE0100392, 4'b0000, 4'd11, cv(0,1,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,1,0), 4'b1010);
    // ADD PC,R2,R3: writeback to R15 also pulses PCWrite; no S so flags hold
    add(32'hE082F003, 4'b0000, 4'd0, fe0, 4'b1010);
    add(32'hE082F003, 4'b0000, 4'd1, de0, 4'b1010);
    add(32'hE082F003, 4'b1111, 4'd6, cv(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,0,0), 4'b1010);
    add(32'hE082F003, 4'b0000, 4'd8, cv(1,1,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,0,0), 4'b1010);
    // ADDEQ PC,R2,R3 with Z=0: suppressed
    add(32'h0082F003, 4'b0000, 4'd0, fe0, 4'b1010);
    add(32'h0082F003, 4'b0000, 4'd1, de0, 4'b1010);
    add(32'h0082F003, 4'b0000, 4'd6, cv(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,0,0), 4'b1010);
    add(32'h0082F003, 4'b0000, 4'd8, 20'h0, 4'b1010);

    // Reset held across an edge
    reset = 1'b1;
    bus.Instr = 32'h0;
    bus.ALUFlags = 4'h0;
    @(posedge clk); #1;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_flags", 32'(bus.Flags), 32'd0);
    chk("reset_ctrl", 32'(actual_ctrl()), 32'(fe0));
    @(negedge clk);
    reset = 1'b0;

    // Vector table, one row per cycle
    foreach (vecs[i]) begin
      bus.Instr = vecs[i].instr;
      bus.ALUFlags = vecs[i].aluf;
      #1;
      chk($sformatf("v%0d_state", i), 32'(bus.state), 32'(vecs[i].st));
      chk($sformatf("v%0d_ctrl", i), 32'(actual_ctrl()), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_flags", i), 32'(bus.Flags), 32'(vecs[i].flags));
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of EXECR of ADD R1,R2,R3
    bus.Instr = 32'hE0821003;
    bus.ALUFlags = 4'b1111;
    #1 chk("rst_pre_fetch", 32'(bus.state), 32'd0);
    @(posedge clk); #1;
    chk("rst_pre_decode", 32'(bus.state), 32'd1);
    @(posedge clk); #1;
    chk("rst_pre_execr", 32'(bus.state), 32'd6);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_state", 32'(bus.state), 32'd0);
    chk("rst_async_flags", 32'(bus.Flags), 32'd0);
    chk("rst_async_ctrl", 32'(actual_ctrl()), 32'(fe0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rel_state", 32'(bus.state), 32'd0);
    chk("rst_rel_wr", 32'({bus.IRWrite, bus.PCWrite, bus.RegWrite}), 32'b110);
    @(posedge clk); #1;
    chk("rst_rel_decode", 32'(bus.state), 32'd1);
    @(posedge clk); #1;
    chk("rst_rel_execr", 32'(bus.state), 32'd6);
    chk("rst_rel_flags_hold", 32'(bus.Flags), 32'd0);
    @(posedge clk); #1;
    chk("rst_rel_aluwb", 32'({bus.state, bus.RegWrite}), {27'd0, 4'd8, 1'b1});
    @(posedge clk); #1;

    // Illegal DP command (MOV class)
    bus.Instr = 32'hE1A00000;
    #1 chk("ill_fetch", 32'(bus.state), 32'd0);
    @(posedge clk); #1;
    chk("ill_decode", 32'(bus.state), 32'd1);
    @(posedge clk); #1;
`ifdef ILLEGAL_HALT_EN
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("halt%0d_state", k), 32'(bus.state), 32'd12);
      chk($sformatf("halt%0d_ctrl", k), 32'(actual_ctrl()), 32'(halt_ctrl));
      @(posedge clk); #1;
    end
`else
    chk("ill_nop_state", 32'(bus.state), 32'd0);
    chk("ill_nop_ctrl", 32'(actual_ctrl()), 32'(fe0));
    chk("ill_nop_flags", 32'(bus.Flags), 32'd0);
    @(posedge clk); #1;
    chk("ill_nop_next", 32'(bus.state), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
